// File: rtl/redpi_pll_ctrl.sv
// redpi_pll_ctrl: power/reset sequencer and lock qualifier for the board clock PLL.
// Runs entirely on the free-running reference clock; PLL output clocks are never used.
module redpi_pll_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 10000,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             force_relock,
  input  logic             pll_locked,
  output logic             pll_reset,
  output logic             pll_power_down,
  output logic             dsp_reset,
  output logic             ready,
  output logic             fail,
  output logic             lock_lost,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] relock_count
);

  localparam int unsigned TMR_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > SETTLE_CYCLES) ? TMR_MAX_A : SETTLE_CYCLES;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
  localparam int unsigned RTY_W     = 8;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_RST    = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [RTY_W-1:0]   rty_inc;
  logic [CNT_W-1:0]   relock_d;
  logic               lost_d;
  logic               lock_meta, locked_s;

  assign state   = 3'(state_q);
  assign rty_inc = rty_q + RTY_W'(1);

  // Two-flop synchronizer for the asynchronous PLL lock output
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // State, timer, retry and relock counter registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_OFF;
      tmr_q        <= '0;
      rty_q        <= '0;
      relock_count <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      rty_q        <= rty_d;
      relock_count <= relock_d;
    end
  end

  // Next-state logic; enable=0 overrides every other transition
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    rty_d    = rty_q;
    relock_d = relock_count;
    lost_d   = 1'b0;
    if (!enable) begin
      state_d = S_OFF;
      tmr_d   = '0;
      rty_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_RST;
          tmr_d   = '0;
        end
        S_RST: begin
          if (tmr_q == TMR_W'(RST_CYCLES - 1)) begin
            state_d = S_WAIT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            state_d = S_SETTLE;
            tmr_d   = '0;
          end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
            tmr_d   = '0;
            rty_d   = rty_inc;
            state_d = (rty_inc == RTY_W'(MAX_RETRIES)) ? S_FAIL : S_RST;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_SETTLE: begin
          if (!locked_s) begin
            state_d = S_WAIT;
            tmr_d   = '0;
          end else if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
            state_d = S_RUN;
            tmr_d   = '0;
            rty_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d  = S_RST;
            tmr_d    = '0;
            lost_d   = 1'b1;
            relock_d = (&relock_count) ? relock_count : relock_count + CNT_W'(1);
          end else if (force_relock) begin
            state_d = S_RST;
            tmr_d   = '0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_OFF;
          tmr_d   = '0;
          rty_d   = '0;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they line up with the state code
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pll_power_down <= 1'b1;
      pll_reset      <= 1'b1;
      dsp_reset      <= 1'b1;
      ready          <= 1'b0;
      fail           <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      pll_power_down <= (state_d == S_OFF) || (state_d == S_FAIL);
      pll_reset      <= (state_d == S_OFF) || (state_d == S_RST) || (state_d == S_FAIL);
      dsp_reset      <= (state_d != S_RUN);
      ready          <= (state_d == S_RUN);
      fail           <= (state_d == S_FAIL);
      lock_lost      <= lost_d;
    end
  end

endmodule
